// File: rtl/gemm_req_arbiter_if.sv
// rtl/gemm_req_arbiter_if.sv - requester/engine bundle for the GEMM request arbiter
//
// Purpose: groups the per-requester job handshake and the engine control
// signals that gemm_req_arbiter sits between.
// Ports (signals):
//   req_valid, req_cfg_m/n/k   requester -> arbiter, one lane per requester
//   req_ready, req_done, req_err  arbiter -> requester, one-hot strobes
//   eng_start, eng_cfg_m/n/k, eng_sel  arbiter -> engine / buffer muxes
//   eng_done                   engine -> arbiter completion pulse
//   busy                       arbiter status
// Modports: slave = arbiter side, master = requesters + engine side.
interface gemm_req_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ROWS    = 16,
   parameter int COLS    = 16,
   parameter int K_MAX   = 2048
);
   localparam int MW = $clog2(ROWS + 1);
   localparam int NW = $clog2(COLS + 1);
   localparam int KW = $clog2(K_MAX + 1);
   localparam int SW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0][MW-1:0] req_cfg_m;
   logic [NUM_REQ-1:0][NW-1:0] req_cfg_n;
   logic [NUM_REQ-1:0][KW-1:0] req_cfg_k;
   logic [NUM_REQ-1:0]         req_ready;
   logic [NUM_REQ-1:0]         req_done;
   logic [NUM_REQ-1:0]         req_err;
   logic                       eng_start;
   logic [MW-1:0]              eng_cfg_m;
   logic [NW-1:0]              eng_cfg_n;
   logic [KW-1:0]              eng_cfg_k;
   logic [SW-1:0]              eng_sel;
   logic                       eng_done;
   logic                       busy;

   modport slave (
      input  req_valid, req_cfg_m, req_cfg_n, req_cfg_k, eng_done,
      output req_ready, req_done, req_err, eng_start,
             eng_cfg_m, eng_cfg_n, eng_cfg_k, eng_sel, busy
   );

   modport master (
      output req_valid, req_cfg_m, req_cfg_n, req_cfg_k, eng_done,
      input  req_ready, req_done, req_err, eng_start,
             eng_cfg_m, eng_cfg_n, eng_cfg_k, eng_sel, busy
   );
endinterface

// File: rtl/gemm_req_arbiter.sv
// rtl/gemm_req_arbiter.sv - round-robin arbiter sharing one GEMM engine
//
// Purpose: grants one pending requester at a time (round-robin from rr_ptr),
// latches its M/N/K job, launches the engine, waits for completion and
// returns a one-cycle req_done to the owner.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    gemm_req_arbiter_if.slave (requester lanes + engine control)
// Optional feature: define GEMM_ARB_TIMEOUT_EN to add a run watchdog that
// aborts a job after TIMEOUT_CYC cycles in S_RUN and pulses req_err with
// req_done. Without it S_RUN waits for eng_done indefinitely.
module gemm_req_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ROWS        = 16,
   parameter int COLS        = 16,
   parameter int K_MAX       = 2048,
   parameter int TIMEOUT_CYC = 65535
) (
   input logic clk,
   input logic rst_n,
   gemm_req_arbiter_if.slave bus
);
   localparam int SW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_RESP} state_t;

   state_t        state;
   state_t        state_nx;
   logic [SW-1:0] rr_ptr;
   logic [SW-1:0] winner;
   logic [SW:0]   cand;
   logic          any_valid;
   logic          accept;
   logic          cfg_zero;
   logic          tmo_hit;
   logic          timed_out;

   // Scan from the farthest offset down so the nearest valid index at or
   // after rr_ptr is the last one written.
   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      cand      = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         cand = {1'b0, rr_ptr} + (SW+1)'(off);
         if (cand >= (SW+1)'(NUM_REQ)) begin
            cand = cand - (SW+1)'(NUM_REQ);
         end
         if (bus.req_valid[cand[SW-1:0]]) begin
            winner    = cand[SW-1:0];
            any_valid = 1'b1;
         end
      end
   end

   assign cfg_zero = (bus.eng_cfg_m == '0) || (bus.eng_cfg_n == '0) ||
                     (bus.eng_cfg_k == '0);
   assign bus.busy = (state != S_IDLE);

`ifdef GEMM_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_cnt;

   // tmo_cnt counts completed cycles in S_RUN; the hit fires on the
   // TIMEOUT_CYC-th cycle so the job leaves after exactly that many.
   assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmo_cnt   <= '0;
         timed_out <= 1'b0;
      end else begin
         if (state == S_LAUNCH) begin
            tmo_cnt <= '0;
         end else if (state == S_RUN) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (state == S_IDLE) begin
            timed_out <= 1'b0;
         end else if (state == S_RUN && !bus.eng_done && tmo_hit) begin
            timed_out <= 1'b1;
         end
      end
   end
`else
   logic unused_tmo;
   assign tmo_hit    = 1'b0;
   assign timed_out  = 1'b0;
   assign unused_tmo = (TIMEOUT_CYC == 0) | tmo_hit | timed_out;
`endif

   always_comb begin
      state_nx      = state;
      accept        = 1'b0;
      bus.req_ready = '0;
      bus.req_done  = '0;
      bus.req_err   = '0;
      bus.eng_start = 1'b0;
      case (state)
         S_IDLE: begin
            // Gated by rst_n so nothing is accepted while reset is held.
            if (any_valid && rst_n) begin
               bus.req_ready[winner] = 1'b1;
               accept                = 1'b1;
               state_nx              = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            if (cfg_zero) begin
               state_nx = S_RESP;
            end else begin
               bus.eng_start = 1'b1;
               state_nx      = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.eng_done || tmo_hit) begin
               state_nx = S_RESP;
            end
         end
         S_RESP: begin
            bus.req_done[bus.eng_sel] = 1'b1;
            bus.req_err[bus.eng_sel]  = timed_out;
            state_nx                  = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         rr_ptr        <= '0;
         bus.eng_sel   <= '0;
         bus.eng_cfg_m <= '0;
         bus.eng_cfg_n <= '0;
         bus.eng_cfg_k <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            bus.eng_sel   <= winner;
            bus.eng_cfg_m <= bus.req_cfg_m[winner];
            bus.eng_cfg_n <= bus.req_cfg_n[winner];
            bus.eng_cfg_k <= bus.req_cfg_k[winner];
         end
         if (state == S_RESP) begin
            rr_ptr <= (bus.eng_sel == SW'(NUM_REQ - 1)) ? '0 : bus.eng_sel + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_gemm_req_arbiter.sv
// tb/tb_gemm_req_arbiter.sv - self-checking bench for gemm_req_arbiter
module tb_gemm_req_arbiter;
   localparam int N   = 4;
   localparam int TMO = 100;
   localparam int MW  = $clog2(16 + 1);
   localparam int NW  = $clog2(16 + 1);
   localparam int KW  = $clog2(2048 + 1);

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   rr_model;
   int   jm [N];
   int   jn [N];
   int   jk [N];

   gemm_req_arbiter_if #(.NUM_REQ(N), .ROWS(16), .COLS(16), .K_MAX(2048)) bus ();

   gemm_req_arbiter #(
      .NUM_REQ(N), .ROWS(16), .COLS(16), .K_MAX(2048), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference grant rule: first valid index at or after the pointer, wrapping.
   function automatic int pick(input logic [N-1:0] m, input int ptr);
      for (int off = 0; off < N; off++) begin
         if (m[(ptr + off) % N]) return (ptr + off) % N;
      end
      return -1;
   endfunction

   function automatic logic [31:0] onehot(input int w);
      return (w < 0) ? 32'd0 : (32'd1 << w);
   endfunction

   task automatic drive_cfg();
      for (int i = 0; i < N; i++) begin
         bus.req_cfg_m[i] = MW'(jm[i]);
         bus.req_cfg_n[i] = NW'(jn[i]);
         bus.req_cfg_k[i] = KW'(jk[i]);
      end
   endtask

   task automatic rand_cfg();
      for (int i = 0; i < N; i++) begin
         jm[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 16));
         jn[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 16));
         jk[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 2048));
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, bus.req_ready, 0);
      check({tag, "_done"},  bus.req_done, 0);
      check({tag, "_err"},   bus.req_err, 0);
      check({tag, "_start"}, bus.eng_start, 0);
      check({tag, "_busy"},  bus.busy, 0);
      check({tag, "_sel"},   bus.eng_sel, 0);
      check({tag, "_cfg"},   {bus.eng_cfg_m, bus.eng_cfg_n, bus.eng_cfg_k}, 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.eng_done  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst_n    = 1'b1;
      rr_model = 0;
   endtask

   // One full transaction: offer mask in S_IDLE, expect the model's winner,
   // then launch, an engine latency of lat cycles, and the response pulse.
   task automatic run_job(input logic [N-1:0] mask, input int lat,
                          input bit hold, input bit glitch);
      int w;
      int em, en, ek;
      bit zero;
      w = pick(mask, rr_model);
      @(posedge clk); #1;
      bus.req_valid = mask;
      drive_cfg();
      bus.eng_done  = glitch;
      @(negedge clk);
      check("grant", bus.req_ready, onehot(w));
      check("idle_busy", bus.busy, 0);
      if (w < 0) begin
         @(posedge clk); #1;
         bus.eng_done = 1'b0;
         @(negedge clk);
         check("no_accept_busy", bus.busy, 0);
         check("no_accept_start", bus.eng_start, 0);
         return;
      end
      em = jm[w]; en = jn[w]; ek = jk[w];
      zero = (em == 0) || (en == 0) || (ek == 0);
      @(posedge clk); #1;
      bus.req_valid = hold ? mask : '0;
      rand_cfg();
      drive_cfg();
      bus.eng_done  = glitch;
      @(negedge clk);
      check("eng_start", bus.eng_start, {31'd0, !zero});
      check("eng_sel", bus.eng_sel, w);
      check("eng_cfg", {bus.eng_cfg_m, bus.eng_cfg_n, bus.eng_cfg_k},
            {MW'(em), NW'(en), KW'(ek)});
      check("launch_ready", bus.req_ready, 0);
      check("launch_done", bus.req_done, 0);
      check("launch_busy", bus.busy, 1);
      if (!zero) begin
         for (int c = 2; c <= lat + 1; c++) begin
            @(posedge clk); #1;
            bus.eng_done = (c == lat + 1);
            @(negedge clk);
            check("run_done", bus.req_done, 0);
            check("run_start", bus.eng_start, 0);
            check("run_ready", bus.req_ready, 0);
         end
      end
      @(posedge clk); #1;
      bus.eng_done = 1'b0;
      @(negedge clk);
      check("req_done", bus.req_done, onehot(w));
      check("req_err", bus.req_err, 0);
      check("resp_ready", bus.req_ready, 0);
      check("resp_cfg_held", {bus.eng_sel, bus.eng_cfg_m, bus.eng_cfg_n, bus.eng_cfg_k},
            {2'(w), MW'(em), NW'(en), KW'(ek)});
      rr_model = (w + 1) % N;
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      rr_model      = 0;
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.eng_done  = 1'b0;
      for (int i = 0; i < N; i++) begin
         jm[i] = 1; jn[i] = 1; jk[i] = 1;
      end
      drive_cfg();

      // Reset, then a single 16x16x64 job from requester 2.
      do_reset();
      jm[2] = 16; jn[2] = 16; jk[2] = 64;
      run_job(4'b0100, 3, 1'b0, 1'b0);

      // All four held valid: order 0,1,2,3,0.
      do_reset();
      for (int i = 0; i < N; i++) begin
         jm[i] = 8; jn[i] = 4; jk[i] = 100 + i;
      end
      for (int j = 0; j < 5; j++) begin
         check("rr_order", pick(4'b1111, rr_model), j % N);
         run_job(4'b1111, 10, 1'b1, 1'b0);
      end

      // Zero-size job: no eng_start, done two cycles after accept.
      jk[0] = 0;
      run_job(4'b0001, 1, 1'b0, 1'b0);
      jk[0] = 5;

      // eng_done pulses in S_IDLE (no request) and S_IDLE/S_LAUNCH (with one).
      run_job(4'b0000, 1, 1'b0, 1'b1);
      run_job(4'b0010, 5, 1'b0, 1'b1);

      // Reset in the middle of S_RUN abandons the owner and clears rr_ptr.
      @(posedge clk); #1;
      bus.req_valid = 4'b1111;
      drive_cfg();
      @(negedge clk);
      check("abort_grant", bus.req_ready, onehot(pick(4'b1111, rr_model)));
      @(posedge clk); #1;
      bus.req_valid = '0;
      repeat (2) @(posedge clk);
      do_reset();
      @(negedge clk);
      check("abort_no_done", bus.req_done, 0);
      check("abort_busy", bus.busy, 0);
      run_job(4'b1111, 2, 1'b0, 1'b0);

`ifdef GEMM_ARB_TIMEOUT_EN
      begin
         int  w;
         int  cyc;
         bit  seen;
         for (int i = 0; i < N; i++) begin
            jm[i] = 4; jn[i] = 4; jk[i] = 4;
         end
         w = pick(4'b0110, rr_model);
         @(posedge clk); #1;
         bus.req_valid = 4'b0110;
         drive_cfg();
         @(negedge clk);
         check("tmo_grant", bus.req_ready, onehot(w));
         @(posedge clk); #1;
         bus.req_valid = '0;
         @(negedge clk);
         check("tmo_start", bus.eng_start, 1);
         cyc  = 0;
         seen = 1'b0;
         while (!seen && cyc < 3 * TMO) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (bus.req_done != 0) seen = 1'b1;
         end
         check("tmo_seen", seen, 1);
         check("tmo_cycles", cyc, TMO + 1);
         check("tmo_done", bus.req_done, onehot(w));
         check("tmo_err", bus.req_err, onehot(w));
         rr_model = (w + 1) % N;
         run_job(4'b0110, 3, 1'b0, 1'b0);
      end
`endif

      // Randomized traffic against the model.
      for (int j = 0; j < 60; j++) begin
         rand_cfg();
         run_job(N'($urandom_range(0, 15)), int'($urandom_range(1, 12)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/gemm_req_arbiter.md
GEMM_REQ_ARBITER -- requirements
Module: gemm_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one GEMM engine (2..8).
REQ-002 Parameter ROWS, default 16: tile rows. MW = $clog2(ROWS+1).
REQ-003 Parameter COLS, default 16: tile cols. NW = $clog2(COLS+1).
REQ-004 Parameter K_MAX, default 2048: max K. KW = $clog2(K_MAX+1).
REQ-005 Parameter TIMEOUT_CYC, default 65535: watchdog limit in cycles.
REQ-006 Ports: one clock; reset is synchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  requester i has a job pending
- req_cfg_m  in  NUM_REQ x MW  job M per requester
- req_cfg_n  in  NUM_REQ x NW  job N per requester
- req_cfg_k  in  NUM_REQ x KW  job K per requester
- req_ready  out  NUM_REQ  one-hot grant/accept strobe
- req_done  out  NUM_REQ  one-cycle completion pulse to owner
- req_err  out  NUM_REQ  one-cycle timeout pulse to owner
- eng_start  out  1  one-cycle engine start
- eng_cfg_m/n/k  out  MW/NW/KW  latched job config
- eng_sel  out  $clog2(NUM_REQ)  owner index, steers buffer muxes
- eng_done  in  1  engine completion pulse
- busy  out  1  high in any state except S_IDLE

Function
REQ-007 FSM states S_IDLE, S_LAUNCH, S_RUN, S_RESP.
REQ-008 S_IDLE: if any req_valid, winner = first valid index at or after rr_ptr (wrapping); req_ready[winner]=1 same cycle (combinational); cfg latched, eng_sel=winner; -> S_LAUNCH.
REQ-009 Accept = req_valid[i] && req_ready[i]; at most one req_ready bit set per cycle; never set outside S_IDLE.
REQ-010 S_LAUNCH: if latched m, n or k is zero -> S_RESP without eng_start; else eng_start=1 for exactly one cycle, -> S_RUN.
REQ-011 S_RUN: eng_done sampled only here; eng_done=1 -> S_RESP. eng_done outside S_RUN ignored.
REQ-012 S_RESP: req_done[owner]=1 for one cycle; rr_ptr <= (owner+1) mod NUM_REQ; -> S_IDLE.
REQ-013 Latency: accept cycle T, eng_start at T+1, eng_done at T+1+L -> req_done at T+2+L; zero-size job req_done at T+2.
REQ-014 eng_cfg_* and eng_sel held stable from S_LAUNCH until return to S_IDLE; req_cfg_* changes after accept have no effect.
REQ-015 Back-to-back: requester may hold req_valid continuously; re-grant only after all other valid requesters served (round-robin fairness).
REQ-016 req_valid deasserted before grant: no accept, no state change.

Reset
REQ-017 rst_n=0 at a clock edge: state=S_IDLE, rr_ptr=0, eng_sel=0, eng_cfg_*=0, counters=0; all outputs 0 next cycle.
REQ-018 Reset mid-job abandons owner with no req_done/req_err; engine is reset by its own rst_n.

Configuration
REQ-019 Macro GEMM_ARB_TIMEOUT_EN defined: cycle counter cleared on S_RUN entry; if it reaches TIMEOUT_CYC without eng_done -> S_RESP, req_err[owner] and req_done[owner] both pulse.
REQ-020 GEMM_ARB_TIMEOUT_EN undefined: no counter; S_RUN waits indefinitely; req_err tied 0.

Verification
REQ-021 rst_n=0 two cycles, then req_valid=4'b0100 cfg 16/16/64 -> req_ready=4'b0100 same cycle, eng_start next cycle, eng_cfg=16/16/64, eng_sel=2.
REQ-022 req_valid=4'b1111 held, eng_done 10 cycles after each eng_start -> grant order 0,1,2,3,0; one req_done per job.
REQ-023 req_valid=4'b0001 cfg k=0 -> no eng_start; req_done[0] two cycles after accept.
REQ-024 eng_done pulsed in S_IDLE and S_LAUNCH -> ignored; FSM stays in S_RUN until later eng_done.
REQ-025 GEMM_ARB_TIMEOUT_EN, TIMEOUT_CYC=100, eng_done never asserted -> req_err[owner] and req_done[owner] pulse after 100 cycles in S_RUN; next requester granted.
REQ-026 rst_n=0 during S_RUN -> busy=0, req_done=0 next cycle; rr_ptr=0 (req_valid=4'b1111 then grants index 0).
